cpu_stage_sequencer: RTL

Registered multi-cycle control sequencer for the MIPS CPU datapath. It steps each instruction through IF, ID, EX, MEM and WB. It issues one-cycle write and enable strobes to the PC, IR, register file, ALU and memories. It stalls on a shared memory-ready handshake and flags hung memory accesses. It sits between the CPU top level and the CU/ALU/Register_file/ROM/RAM instances and replaces combinational stage logic with a single clocked FSM.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/cpu_stage_sequencer_if.sv | 43 ++++
 rtl/seq_wait_timer.sv | 39 +++
 rtl/cpu_stage_sequencer.sv | 127 ++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Brief    : State encoding and default wait limit for cpu_stage_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int unsigned c_STATE_W = 3;

  localparam logic [2:0] c_ST_IF   = 3'd0;
  localparam logic [2:0] c_ST_ID   = 3'd1;
  localparam logic [2:0] c_ST_EX   = 3'd2;
  localparam logic [2:0] c_ST_MEM  = 3'd3;
  localparam logic [2:0] c_ST_WB   = 3'd4;
  localparam logic [2:0] c_ST_IDLE = 3'd5;
  localparam logic [2:0] c_ST_ERR  = 3'd6;

  localparam int c_MEM_TIMEOUT_DEF = 15;

endpackage

`default_nettype wire

// File: rtl/cpu_stage_sequencer_if.sv
// ============================================================================
// Module   : cpu_stage_sequencer_if
// Brief    : Control/strobe bundle between the CPU top and the stage sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpu_stage_sequencer_if #(
  parameter int CNT_W = 32
) ();
  logic             en;
  logic             err_clr;
  logic             is_load;
  logic             is_store;
  logic             reg_write;
  logic             mem_ready;
  logic [2:0]       state;
  logic             imem_req;
  logic             ir_we;
  logic             rf_re;
  logic             alu_en;
  logic             mem_re;
  logic             mem_we;
  logic             rf_we;
  logic             pc_we;
  logic             busy;
  logic             error;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output en, err_clr, is_load, is_store, reg_write, mem_ready,
    input  state, imem_req, ir_we, rf_re, alu_en, mem_re, mem_we,
           rf_we, pc_we, busy, error, instr_count
  );

  modport slave (
    input  en, err_clr, is_load, is_store, reg_write, mem_ready,
    output state, imem_req, ir_we, rf_re, alu_en, mem_re, mem_we,
           rf_we, pc_we, busy, error, instr_count
  );
endinterface

`default_nettype wire

// File: rtl/seq_wait_timer.sv
// ============================================================================
// Module   : seq_wait_timer
// Brief    : Memory wait counter; o_expire fires on the wait cycle that
//            brings the count to MEM_TIMEOUT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_wait_timer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = c_MEM_TIMEOUT_DEF
) (
  input  wire logic clk,
  input  wire logic reset_n,
  input  wire logic i_clr,
  input  wire logic i_inc,
  output logic      o_expire
);
  localparam int              c_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_W-1:0]  c_LAST = c_W'(MEM_TIMEOUT - 1);

  logic [c_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !o_expire) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expire = i_inc && (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/cpu_stage_sequencer.sv
// ============================================================================
// Module   : cpu_stage_sequencer
// Brief    : Clocked IF/ID/EX/MEM/WB control FSM with memory-wait timeout.
//            Optional macro CPU_SEQ_MEM_SKIP_EN: EX jumps to WB for non-memory ops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_stage_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = c_MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 32
) (
  input wire logic             clk,
  input wire logic             reset_n,
  cpu_stage_sequencer_if.slave bus
);
  logic [c_STATE_W-1:0] r_state;
  logic [c_STATE_W-1:0] w_next;
  logic [CNT_W-1:0]     r_instr_count;
  logic w_access, w_waiting_state, w_wait_inc, w_expire;
  logic w_imem_req, w_ir_we, w_rf_re, w_alu_en, w_mem_re, w_mem_we;
  logic w_rf_we, w_pc_we, w_busy, w_error;

  assign w_access        = bus.is_load | bus.is_store;
  // Only IF and an accessing MEM actually wait on the shared handshake.
  assign w_waiting_state = (r_state == c_ST_IF) || ((r_state == c_ST_MEM) && w_access);
  assign w_wait_inc      = w_waiting_state && !bus.mem_ready;

  seq_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clr    (!w_waiting_state),
    .i_inc    (w_wait_inc),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE: w_next = bus.en ? c_ST_IF : c_ST_IDLE;
      c_ST_IF: begin
        if (w_expire)           w_next = c_ST_ERR;
        else if (bus.mem_ready) w_next = c_ST_ID;
      end
      c_ST_ID: w_next = c_ST_EX;
      c_ST_EX: begin
        if (bus.is_load && bus.is_store) w_next = c_ST_ERR;
`ifdef CPU_SEQ_MEM_SKIP_EN
        else if (!w_access)              w_next = c_ST_WB;
`endif
        else                             w_next = c_ST_MEM;
      end
      c_ST_MEM: begin
        if (!w_access)          w_next = c_ST_WB;
        else if (w_expire)      w_next = c_ST_ERR;
        else if (bus.mem_ready) w_next = c_ST_WB;
      end
      c_ST_WB:  w_next = bus.en ? c_ST_IF : c_ST_IDLE;
      c_ST_ERR: w_next = bus.err_clr ? c_ST_IDLE : c_ST_ERR;
      default:  w_next = c_ST_ERR;
    endcase
  end

  always_comb begin
    w_imem_req = 1'b0;
    w_ir_we    = 1'b0;
    w_rf_re    = 1'b0;
    w_alu_en   = 1'b0;
    w_mem_re   = 1'b0;
    w_mem_we   = 1'b0;
    w_rf_we    = 1'b0;
    w_pc_we    = 1'b0;
    w_busy     = (r_state != c_ST_IDLE) && (r_state != c_ST_ERR);
    w_error    = (r_state == c_ST_ERR);
    case (r_state)
      c_ST_IF: begin
        w_imem_req = 1'b1;
        w_ir_we    = bus.mem_ready;
      end
      c_ST_ID:  w_rf_re  = 1'b1;
      c_ST_EX:  w_alu_en = 1'b1;
      c_ST_MEM: begin
        w_mem_re = bus.is_load;
        w_mem_we = bus.is_store;
      end
      c_ST_WB: begin
        w_rf_we = bus.reg_write;
        w_pc_we = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instr_count <= '0;
    end else if (r_state == c_ST_WB) begin
      r_instr_count <= r_instr_count + 1'b1;
    end
  end

  assign bus.state       = r_state;
  assign bus.imem_req    = w_imem_req;
  assign bus.ir_we       = w_ir_we;
  assign bus.rf_re       = w_rf_re;
  assign bus.alu_en      = w_alu_en;
  assign bus.mem_re      = w_mem_re;
  assign bus.mem_we      = w_mem_we;
  assign bus.rf_we       = w_rf_we;
  assign bus.pc_we       = w_pc_we;
  assign bus.busy        = w_busy;
  assign bus.error       = w_error;
  assign bus.instr_count = r_instr_count;

endmodule

`default_nettype wire
